// File: rtl/vacc_readout.sv
// Vector accumulator readout: captures drained spectra into ping-pong banks with
// saturating requantisation and streams completed vectors over AXI-Stream.
module vacc_readout #(
  parameter int VECTOR_WIDTH = 11,
  parameter int IN_WIDTH     = 32,
  parameter int OUT_WIDTH    = 16,
  parameter int SHIFT        = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic [IN_WIDTH-1:0]     data_in,
  input  logic                    we,
  input  logic [VECTOR_WIDTH-1:0] addr,
  output logic [OUT_WIDTH-1:0]    m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [15:0]             m_tuser,
  output logic [15:0]             dropped,
  output logic                    overflow,
  input  logic                    clear_overflow
);

  localparam int DEPTH = 1 << VECTOR_WIDTH;
  localparam logic [VECTOR_WIDTH-1:0] LAST_ADDR = {VECTOR_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, FILL, DROP} cap_state_t;
  typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

  function automatic logic [OUT_WIDTH-1:0] requant(input logic [IN_WIDTH-1:0] d);
    logic [IN_WIDTH-1:0] v;
    v = d >> SHIFT;
    if ((v >> OUT_WIDTH) != '0) requant = '1;
    else                        requant = v[OUT_WIDTH-1:0];
  endfunction

  logic [OUT_WIDTH-1:0]    r_mem [0:2*DEPTH-1];
  cap_state_t              r_cap_state;
  rd_state_t               r_rd_state;
  logic                    r_wr_bank, r_rd_bank;
  logic [1:0]              r_bank_full;
  logic [15:0]             r_tag [0:1];
  logic [15:0]             r_seq, r_dropped;
  logic                    r_overflow;
  logic [VECTOR_WIDTH-1:0] r_rd_addr;
  logic                    r_issue_done;
  logic                    r_ram_v, r_ram_last;
  logic [15:0]             r_ram_user;
  logic [OUT_WIDTH-1:0]    r_ram_data;
  logic                    r_out_v, r_out_last, r_skid_v, r_skid_last;
  logic [15:0]             r_out_user, r_skid_user;
  logic [OUT_WIDTH-1:0]    r_out_data, r_skid_data;

  logic                    w_cap, w_last_addr, w_pop, w_release, w_wr_full;
  logic                    w_start_drop, w_mem_we, w_fill_done, w_issue;
  logic [1:0]              w_occ, w_set, w_clr;
  logic [VECTOR_WIDTH-1:0] w_rd_ptr;

  assign w_cap       = ce && we;
  assign w_last_addr = (addr == LAST_ADDR);
  assign w_pop       = r_out_v && m_tready;
  assign w_release   = w_pop && r_out_last;
  // A bank released this cycle counts as free for a vector starting now.
  assign w_wr_full    = r_bank_full[r_wr_bank] && !(w_release && (r_rd_bank == r_wr_bank));
  assign w_start_drop = w_cap && (r_cap_state == IDLE) && (addr == '0) && w_wr_full;
  assign w_mem_we     = w_cap && (((r_cap_state == IDLE) && (addr == '0) && !w_wr_full) ||
                                  (r_cap_state == FILL));
  assign w_fill_done  = w_cap && (r_cap_state == FILL) && w_last_addr;
  assign w_set        = w_fill_done ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr        = w_release   ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

  // Words held downstream of the RAM after this edge's pop; reads issue only while it fits the skid pair.
  assign w_occ    = 2'(r_out_v) + 2'(r_skid_v) + 2'(r_ram_v) - 2'(w_pop);
  assign w_rd_ptr = (r_rd_state == R_IDLE) ? '0 : r_rd_addr;
  assign w_issue  = (r_rd_state == R_IDLE) ? r_bank_full[r_rd_bank]
                                           : (!r_issue_done && (w_occ < 2'd2));

  assign m_tdata  = r_out_data;
  assign m_tvalid = r_out_v;
  assign m_tlast  = r_out_last;
  assign m_tuser  = r_out_user;
  assign dropped  = r_dropped;
  assign overflow = r_overflow;

  // Capture FSM, sequence numbering and drop accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_state <= IDLE;
      r_wr_bank   <= 1'b0;
      r_seq       <= 16'd0;
      r_tag[0]    <= 16'd0;
      r_tag[1]    <= 16'd0;
      r_dropped   <= 16'd0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_cap) begin
        case (r_cap_state)
          IDLE: begin
            if (addr == '0) begin
              if (w_wr_full) begin
                r_cap_state <= DROP;
              end else begin
                r_cap_state      <= FILL;
                r_tag[r_wr_bank] <= r_seq;
              end
              r_seq <= r_seq + 16'd1;
            end
          end
          FILL: begin
            if (w_last_addr) begin
              r_cap_state <= IDLE;
              r_wr_bank   <= ~r_wr_bank;
            end
          end
          DROP: begin
            if (w_last_addr) r_cap_state <= IDLE;
          end
          default: r_cap_state <= IDLE;
        endcase
      end
      if (w_start_drop) begin
        r_overflow <= 1'b1;
        if (clear_overflow)              r_dropped <= 16'd1;
        else if (r_dropped != 16'hFFFF)  r_dropped <= r_dropped + 16'd1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
        r_dropped  <= 16'd0;
      end
    end
  end

  // Bank occupancy flags: capture sets, stream completion clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bank_full <= 2'b00;
    else        r_bank_full <= (r_bank_full | w_set) & ~w_clr;
  end

  // Bank RAM with registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[{r_wr_bank, addr}] <= requant(data_in);
    if (w_issue)  r_ram_data <= r_mem[{r_rd_bank, w_rd_ptr}];
  end

  // Read FSM and RAM read issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state   <= R_IDLE;
      r_rd_bank    <= 1'b0;
      r_rd_addr    <= '0;
      r_issue_done <= 1'b0;
      r_ram_v      <= 1'b0;
      r_ram_last   <= 1'b0;
      r_ram_user   <= 16'd0;
    end else begin
      r_ram_v <= w_issue;
      if (w_issue) begin
        r_rd_addr    <= w_rd_ptr + VECTOR_WIDTH'(1);
        r_issue_done <= (w_rd_ptr == LAST_ADDR);
        r_ram_last   <= (w_rd_ptr == LAST_ADDR);
        r_ram_user   <= r_tag[r_rd_bank];
      end
      case (r_rd_state)
        R_IDLE: begin
          if (r_bank_full[r_rd_bank]) r_rd_state <= R_STREAM;
        end
        R_STREAM: begin
          if (w_release) begin
            r_rd_bank    <= ~r_rd_bank;
            r_rd_addr    <= '0;
            r_issue_done <= 1'b0;
            r_rd_state   <= r_bank_full[~r_rd_bank] ? R_STREAM : R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Output register plus skid entry; oldest word always sits in the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v     <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_user  <= 16'd0;
      r_out_data  <= '0;
      r_skid_v    <= 1'b0;
      r_skid_last <= 1'b0;
      r_skid_user <= 16'd0;
      r_skid_data <= '0;
    end else if (r_out_v && !w_pop) begin
      if (!r_skid_v && r_ram_v) begin
        r_skid_v    <= 1'b1;
        r_skid_last <= r_ram_last;
        r_skid_user <= r_ram_user;
        r_skid_data <= r_ram_data;
      end
    end else if (r_skid_v) begin
      r_out_v     <= 1'b1;
      r_out_last  <= r_skid_last;
      r_out_user  <= r_skid_user;
      r_out_data  <= r_skid_data;
      r_skid_v    <= r_ram_v;
      r_skid_last <= r_ram_last;
      r_skid_user <= r_ram_user;
      r_skid_data <= r_ram_data;
    end else begin
      r_out_v <= r_ram_v;
      if (r_ram_v) begin
        r_out_last <= r_ram_last;
        r_out_user <= r_ram_user;
        r_out_data <= r_ram_data;
      end
    end
  end

endmodule

// File: tb/tb_vacc_readout.sv
// Directed bench for vacc_readout with an 8-channel vector (VECTOR_WIDTH=3).
module tb_vacc_readout;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        we = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [15:0] m_tuser;
  logic [15:0] dropped;
  logic        overflow;
  logic        clear_overflow = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] vec_in  [8];
  logic [15:0] exp_out [8];

  vacc_readout #(.VECTOR_WIDTH(3), .IN_WIDTH(32), .OUT_WIDTH(16), .SHIFT(8)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .data_in(data_in), .we(we), .addr(addr),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .dropped(dropped), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ce = 1'b0; we = 1'b0; addr = 3'd0; data_in = 32'd0; clear_overflow = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Expected word k is k<<8 >> 8 = k plus an offset.
  task automatic load_ramp(input int offs);
    for (int k = 0; k < 8; k++) begin
      vec_in[k]  = 32'(k + offs) << 8;
      exp_out[k] = 16'(k + offs);
    end
  endtask

  task automatic send_vec(input bit clr0);
    for (int k = 0; k < 8; k++) begin
      ce = 1'b1; we = 1'b1; addr = 3'(k); data_in = vec_in[k];
      clear_overflow = clr0 && (k == 0);
      tick();
    end
    we = 1'b0; clear_overflow = 1'b0;
  endtask

  task automatic recv_vec(input logic [15:0] user, input bit rnd, input string tag);
    int beat; int guard; bit stalled;
    logic [15:0] hd; logic hl; logic [15:0] hu;
    beat = 0; guard = 0; stalled = 1'b0; hd = 16'd0; hl = 1'b0; hu = 16'd0;
    while (beat < 8 && guard < 300) begin
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check({tag, "_hold_valid"}, 32'(m_tvalid), 32'd1);
        check({tag, "_hold_data"},  32'(m_tdata),  32'(hd));
        check({tag, "_hold_last"},  32'(m_tlast),  32'(hl));
        check({tag, "_hold_user"},  32'(m_tuser),  32'(hu));
      end
      stalled = 1'b0;
      if (m_tvalid && m_tready) begin
        check({tag, "_data"}, 32'(m_tdata), 32'(exp_out[beat]));
        check({tag, "_last"}, 32'(m_tlast), 32'(beat == 7));
        check({tag, "_user"}, 32'(m_tuser), 32'(user));
        beat++;
      end else if (m_tvalid) begin
        hd = m_tdata; hl = m_tlast; hu = m_tuser; stalled = 1'b1;
      end
      tick();
      guard++;
    end
    check({tag, "_beats"}, 32'(beat), 32'd8);
    m_tready = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_valid", 32'(m_tvalid), 32'd0);
    check("rst_last",  32'(m_tlast),  32'd0);
    check("rst_data",  32'(m_tdata),  32'd0);
    check("rst_user",  32'(m_tuser),  32'd0);
    check("rst_drop",  32'(dropped),  32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);

    // Basic capture and latency
    m_tready = 1'b1;
    load_ramp(0);
    send_vec(1'b0);
    check("t1_lat0", 32'(m_tvalid), 32'd0);
    tick();
    check("t1_lat1", 32'(m_tvalid), 32'd0);
    tick();
    check("t1_lat2", 32'(m_tvalid), 32'd1);
    recv_vec(16'd0, 1'b0, "t1");
    check("t1_idle", 32'(m_tvalid), 32'd0);

    // Backpressure
    m_tready = 1'b0;
    send_vec(1'b0);
    recv_vec(16'd1, 1'b1, "t2");
    check("t2_idle", 32'(m_tvalid), 32'd0);

    // Saturation
    load_ramp(0);
    vec_in[0] = 32'h0100_0000; exp_out[0] = 16'hFFFF;
    vec_in[1] = 32'h00FF_FF00; exp_out[1] = 16'hFFFF;
    vec_in[2] = 32'h0000_1234; exp_out[2] = 16'h0012;
    send_vec(1'b0);
    recv_vec(16'd2, 1'b0, "t3");

    // Overflow: A, B fill both banks, C dropped, D shows the sequence gap
    do_reset();
    m_tready = 1'b0;
    load_ramp(1);
    send_vec(1'b0);
    send_vec(1'b0);
    send_vec(1'b0);
    check("t4_drop", 32'(dropped),  32'd1);
    check("t4_ovf",  32'(overflow), 32'd1);
    recv_vec(16'd0, 1'b0, "t4_a");
    recv_vec(16'd1, 1'b0, "t4_b");
    load_ramp(2);
    send_vec(1'b0);
    recv_vec(16'd3, 1'b0, "t4_d");
    check("t4_drop_keep", 32'(dropped), 32'd1);
    // E, F fill both banks; G drop coincides with clear_overflow
    m_tready = 1'b0;
    send_vec(1'b0);
    send_vec(1'b0);
    send_vec(1'b1);
    check("t4_clrdrop_cnt", 32'(dropped),  32'd1);
    check("t4_clrdrop_ovf", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t4_clr_cnt", 32'(dropped),  32'd0);
    check("t4_clr_ovf", 32'(overflow), 32'd0);
    recv_vec(16'd4, 1'b0, "t4_e");
    recv_vec(16'd5, 1'b0, "t4_f");
    check("t4_idle", 32'(m_tvalid), 32'd0);

    // Mid-vector start ignored; ce-low cycles write nothing
    m_tready = 1'b1;
    for (int k = 5; k < 8; k++) begin
      ce = 1'b1; we = 1'b1; addr = 3'(k); data_in = 32'h0000_7700;
      tick();
    end
    we = 1'b0;
    tick(); tick(); tick();
    check("t5_ignored", 32'(m_tvalid), 32'd0);
    load_ramp(16);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        for (int j = 0; j < 3; j++) begin
          ce = 1'b0; we = 1'b1; addr = 3'd7; data_in = 32'h0000_EE00;
          tick();
        end
      end
      ce = 1'b1; we = 1'b1; addr = 3'(k); data_in = vec_in[k];
      tick();
    end
    we = 1'b0;
    recv_vec(16'd7, 1'b0, "t5");
    check("t5_idle", 32'(m_tvalid), 32'd0);
    check("t5_drop", 32'(dropped),  32'd0);

    // Asynchronous reset mid-stream
    load_ramp(0);
    send_vec(1'b0);
    tick(); tick();
    check("t6_beat0", 32'(m_tdata), 32'd0);
    tick(); tick();
    check("t6_beat2", 32'(m_tdata), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(m_tvalid), 32'd0);
    check("t6_async_user",  32'(m_tuser),  32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    check("t6_no_residual", 32'(m_tvalid), 32'd0);
    load_ramp(3);
    send_vec(1'b0);
    recv_vec(16'd0, 1'b0, "t6");
    check("t6_idle", 32'(m_tvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vacc_readout.md
Name: vacc_readout

Overview:
- Sits directly downstream of the vector accumulator.
- Captures each drained spectrum (write-enable, address and data stream) into one of two ping-pong banks, requantises each word to OUT_WIDTH bits with saturation, and streams completed vectors out over an AXI-Stream master with full backpressure.
- When both banks are occupied, incoming vectors are dropped and counted, never corrupted.

Parameters:
- VECTOR_WIDTH, 11, log2 of channels per vector (bank depth 2^VECTOR_WIDTH).
- IN_WIDTH, 32, accumulator word width.
- OUT_WIDTH, 16, streamed word width.
- SHIFT, 8, right shift applied before saturation; 0 <= SHIFT <= IN_WIDTH-OUT_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable, gates the capture side only.
- data_in  in  IN_WIDTH  accumulated word.
- we  in  1  data_in valid at addr.
- addr  in  VECTOR_WIDTH  channel index of data_in.
- m_tdata  out  OUT_WIDTH  requantised word.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  high on channel 2^VECTOR_WIDTH-1.
- m_tuser  out  16  capture sequence number of the vector being streamed.
- dropped  out  16  count of dropped vectors; saturates at 0xFFFF.
- overflow  out  1  sticky, set on any drop.
- clear_overflow  in  1  synchronous clear of overflow and dropped.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - m_tvalid, m_tlast, m_tdata, m_tuser, dropped and overflow go to 0 immediately.
  - Both banks marked empty; wr_bank = rd_bank = 0; sequence counter = 0.
  - Capture FSM goes to IDLE; read FSM goes to R_IDLE.
  - RAM contents are not cleared.
  - Reset mid-operation discards any partial or pending vector.
- Requantisation, applied at capture:
  - v = data_in >> SHIFT.
  - Stored word = v if v < 2^OUT_WIDTH, else all ones.
  - Banks store OUT_WIDTH bits.
- Capture FSM, advances only on ce && we:
  - IDLE:
    - addr == 0 and bank_full[wr_bank] == 0 -> FILL; write word 0; latch seq into bank tag; seq++.
    - addr == 0 and bank_full[wr_bank] == 1 -> DROP; dropped++ (saturating); overflow = 1; seq++.
    - addr != 0 -> ignored (mid-vector start).
  - FILL:
    - Write every word at addr into wr_bank.
    - The write with addr == 2^VECTOR_WIDTH-1 sets bank_full[wr_bank], toggles wr_bank and returns to IDLE.
  - DROP: discard words; addr == 2^VECTOR_WIDTH-1 -> IDLE.
  - ce low: capture state, counters and RAM writes all hold.
- Read FSM, runs every clk independent of ce:
  - R_IDLE -> R_STREAM when bank_full[rd_bank]; read address starts at 0.
  - RAM read latency is 1 cycle. A 2-entry skid/output register keeps the stream gap-free at 100% m_tready.
  - m_tvalid rises exactly 2 cycles after the clk edge that sampled the final capture write, when the read side is idle.
  - While m_tvalid && !m_tready: m_tdata, m_tlast and m_tuser must hold stable; no word lost or duplicated.
  - m_tuser = tag of rd_bank, constant for the whole vector.
  - Handshake with m_tlast: clear bank_full[rd_bank], toggle rd_bank, then go to R_IDLE, or straight back to R_STREAM if the other bank is full.
- Simultaneous events:
  - Set of one bank's full flag and clear of the other's in the same cycle both take effect.
  - A vector whose addr 0 arrives in the same cycle the matching bank is released is captured, not dropped; full clear takes priority for the capture decision.
  - clear_overflow coinciding with a new drop leaves dropped = 1 and overflow = 1.
- Sequence counter wraps 0xFFFF -> 0. Dropped vectors consume a sequence number, so gaps in m_tuser reveal drops.

Test Plan:
1. Basic capture:
   - Stimulus: VECTOR_WIDTH=3, SHIFT=8, OUT_WIDTH=16; write addr 0..7 with data k<<8, m_tready=1.
   - Response: m_tdata 0..7, m_tlast only on the 8th beat, m_tuser=0; m_tvalid rises 2 cycles after the addr 7 write.
2. Backpressure:
   - Stimulus: same vector, m_tready driven by a random 50% pattern.
   - Response: identical 8 beats in order; outputs stable during every stall.
3. Saturation:
   - Stimulus: data_in=0x01000000 and 0x00FFFF00.
   - Response: 0xFFFF and 0xFFFF.
   - Stimulus: data_in=0x00001234.
   - Response: 0x0012.
4. Overflow:
   - Stimulus: m_tready=0; send 3 full vectors A, B, C.
   - Response: dropped=1, overflow=1.
   - Stimulus: raise m_tready; then send D.
   - Response: A streams with tuser 0, then B with tuser 1; D streams with tuser 3.
   - Stimulus: clear_overflow.
   - Response: dropped=0, overflow=0.
5. Mid-vector start and ce:
   - Stimulus: writes begin at addr 5; ce held low for 3 cycles mid-vector.
   - Response: addr 5..7 ignored; the following 0..7 vector is captured intact, and the ce-low cycles produce no writes.
6. Reset mid-stream:
   - Stimulus: assert rst_n low on beat 3 of a stream.
   - Response: m_tvalid falls without waiting for clk; after release, no residual beats; next full vector streams with tuser=0.
